// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with two-entry skid buffer, flush and saturating kill counter
module pipe_stage_skid #(
  parameter int               WIDTH          = 64,
  parameter logic [WIDTH-1:0] BUBBLE_VAL     = '0,
  parameter bit               CLEAR_ON_EMPTY = 1'b1,
  parameter int               CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] kill_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t           state;
  logic [WIDTH-1:0] skid;
  logic             accept, dequeue;
  logic [1:0]       kills;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] kill_next;
  assign accept  = in_valid & in_ready;
  assign dequeue = out_valid & out_ready;
  // beats lost to a flush: held entries not leaving this cycle plus any beat accepted this cycle
  always_comb begin
    kills     = (state == TWO ? 2'd2 : state == ONE ? 2'd1 : 2'd0) - {1'b0, dequeue} + {1'b0, accept};
    cnt_sum   = {1'b0, kill_cnt} + (CNT_W + 1)'(kills);
    kill_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= BUBBLE_VAL;
      skid      <= BUBBLE_VAL;
      kill_cnt  <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= BUBBLE_VAL;
      skid      <= BUBBLE_VAL;
      kill_cnt  <= kill_next;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state     <= ONE;
          out_valid <= 1'b1;
          out_data  <= in_data;
        end
        ONE: if (accept && dequeue) begin
          out_data <= in_data;
        end else if (accept) begin
          state    <= TWO;
          in_ready <= 1'b0;
          skid     <= in_data;
        end else if (dequeue) begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          if (CLEAR_ON_EMPTY) out_data <= BUBBLE_VAL;
        end
        TWO: if (dequeue) begin
          state    <= ONE;
          in_ready <= 1'b1;
          out_data <= skid;
          skid     <= BUBBLE_VAL;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scenario tasks plus a FIFO scoreboard of accepted beats checked on every dequeue
module tb_pipe_stage_skid;
  localparam int          W   = 16;
  localparam logic [15:0] BUB = 16'hDEAD;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         flush = 1'b0;
  logic [1:0]   kill_cnt;
  int           tests = 0, fails = 0;
  bit           armed = 1'b0;
  logic [W-1:0] q[$];
  int           exp_kill = 0;

  pipe_stage_skid #(.WIDTH(W), .BUBBLE_VAL(BUB), .CLEAR_ON_EMPTY(1'b1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .kill_cnt(kill_cnt)
  );

  always #5 clk = ~clk;

  // one clock: scoreboard the upcoming edge at negedge, then return 1ns after the posedge
  task automatic cycle();
    int  held;
    bit  deq, acc;
    @(negedge clk);
    if (rst && armed) begin
      held = q.size();
      tests++;
      if (out_valid !== (held > 0)) begin fails++; $display("FAIL sb_valid got=%b exp=%b", out_valid, held > 0); end
      tests++;
      if (in_ready !== (held < 2)) begin fails++; $display("FAIL sb_ready got=%b exp=%b", in_ready, held < 2); end
      tests++;
      if (kill_cnt !== 2'(exp_kill)) begin fails++; $display("FAIL sb_kill got=%0d exp=%0d", kill_cnt, exp_kill); end
      deq = (held > 0) && out_ready;
      acc = in_valid && (held < 2);
      if (deq) begin
        tests++;
        if (out_data !== q[0]) begin fails++; $display("FAIL sb_data got=%h exp=%h", out_data, q[0]); end
        void'(q.pop_front());
      end
      if (acc) q.push_back(in_data);
      if (flush) begin
        exp_kill = exp_kill + held - int'(deq) + int'(acc);
        if (exp_kill > 3) exp_kill = 3;
        q.delete();
      end
    end else begin
      q.delete();
      exp_kill = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1; in_data = d;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
    cycle();
    rst = 1'b1; in_valid = 1'b0; armed = 1'b1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    tests++; if (out_data !== BUB) begin fails++; $display("FAIL reset_data got=%h exp=%h", out_data, BUB); end
    tests++; if (kill_cnt !== 2'd0) begin fails++; $display("FAIL reset_kill got=%0d exp=0", kill_cnt); end
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 16'(i);
      cycle();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, in_ready); end
      tests++; if (out_data !== 16'(i)) begin fails++; $display("FAIL stream_data got=%h exp=%h", out_data, 16'(i)); end
    end
    in_valid = 1'b0;
    cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    tests++; if (out_data !== BUB) begin fails++; $display("FAIL drain_bubble got=%h exp=%h", out_data, BUB); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    push(16'h0011);
    push(16'h0022);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
    tests++; if (out_data !== 16'h0011) begin fails++; $display("FAIL bp_main got=%h exp=0011", out_data); end
    cycle();
    tests++; if (out_data !== 16'h0011) begin fails++; $display("FAIL bp_hold got=%h exp=0011", out_data); end
    out_ready = 1'b1;
    cycle();
    tests++; if (out_data !== 16'h0022) begin fails++; $display("FAIL bp_second got=%h exp=0022", out_data); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_reopen got=%b exp=1", in_ready); end
    cycle();
    idle_inputs();
  endtask

  task automatic test_flush_two();
    idle_inputs();
    push(16'h0033);
    push(16'h0044);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL f2_valid got=%b exp=0", out_valid); end
    tests++; if (out_data !== BUB) begin fails++; $display("FAIL f2_data got=%h exp=%h", out_data, BUB); end
    tests++; if (kill_cnt !== 2'd2) begin fails++; $display("FAIL f2_kill got=%0d exp=2", kill_cnt); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    push(16'h0055);
    push(16'h0066);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rm_ready got=%b exp=1", in_ready); end
    tests++; if (out_data !== BUB) begin fails++; $display("FAIL rm_data got=%h exp=%h", out_data, BUB); end
    tests++; if (kill_cnt !== 2'd0) begin fails++; $display("FAIL rm_kill got=%0d exp=0", kill_cnt); end
  endtask

  task automatic test_flush_one();
    idle_inputs();
    push(16'h0077);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0088; flush = 1'b1;
    cycle();
    idle_inputs();
    tests++; if (kill_cnt !== 2'd1) begin fails++; $display("FAIL f1_kill got=%0d exp=1", kill_cnt); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL f1_valid got=%b exp=0", out_valid); end
    cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL f1_dropped got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [3];
    exp_sat[0] = 2'd2; exp_sat[1] = 2'd3; exp_sat[2] = 2'd3;
    idle_inputs();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(16'(16'h0100 + k));
      push(16'(16'h0200 + k));
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      tests++; if (kill_cnt !== exp_sat[k]) begin fails++; $display("FAIL sat_kill k=%0d got=%0d exp=%0d", k, kill_cnt, exp_sat[k]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle_inputs();
    out_ready = 1'b1;
    cycle(); cycle(); cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rand_drain got=%b exp=0", out_valid); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_two();
    test_reset_mid();
    test_flush_one();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
